// File: rtl/cam_pkg.sv
// Shared encodings for the CAM entry manager: response status, request op and FSM states.
package cam_pkg;

  typedef enum logic [1:0] {
    CAM_OK        = 2'd0,
    CAM_EXISTS    = 2'd1,
    CAM_FULL      = 2'd2,
    CAM_NOT_FOUND = 2'd3
  } cam_status_t;

  typedef enum logic {
    CAM_OP_INSERT = 1'b0,
    CAM_OP_DELETE = 1'b1
  } cam_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_DECIDE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } cam_state_t;

endpackage

// File: rtl/priority_encoder.sv
// One-hot-free priority encoder: index of the highest-priority set bit, purely combinational.
// LSB_PRIORITY "HIGH" selects the lowest set index; anything else selects the highest.
module priority_encoder #(
  parameter int    WIDTH        = 32,
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded
);

  localparam int EW = $clog2(WIDTH);

  always_comb begin
    output_valid   = |input_unencoded;
    output_encoded = '0;
    if (LSB_PRIORITY == "HIGH") begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (input_unencoded[i]) output_encoded = EW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (input_unencoded[i]) output_encoded = EW'(i);
      end
    end
  end

endmodule

// File: rtl/cam_entry_manager.sv
// Key-addressed insert/delete front end for a BRAM CAM; lowest-free allocation, occupancy tracking.
// Latency 3 cycles for refusals, 7/9 for delete/insert; one request in flight, req_ready gated by CAM busy.
module cam_entry_manager
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  resp_valid,
  output logic [1:0]            resp_status,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] OCC_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  cam_state_t              state, state_nxt;
  cam_op_t                 op_q;
  logic [DATA_WIDTH-1:0]   key_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  cam_status_t             status_q;
  logic [ENTRIES-1:0]      valid_map;
  logic [ADDR_WIDTH:0]     occupancy_q;
  logic                    free_valid;
  logic [ADDR_WIDTH-1:0]   free_addr;
  logic                    cam_full;

  priority_encoder #(
    .WIDTH        (ENTRIES),
    .LSB_PRIORITY ("HIGH")
  ) u_free_enc (
    .input_unencoded (~valid_map),
    .output_valid    (free_valid),
    .output_encoded  (free_addr)
  );

  assign cam_full = (occupancy_q == FULL_COUNT) || !free_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid && req_ready) state_nxt = ST_LOOKUP;
      ST_LOOKUP: state_nxt = ST_DECIDE;
      ST_DECIDE: begin
        if (op_q == CAM_OP_INSERT) state_nxt = (cam_match || cam_full) ? ST_RESP : ST_ISSUE;
        else                       state_nxt = cam_match ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE:  if (!cam_write_busy) state_nxt = ST_WAIT;
      ST_WAIT:   if (!cam_write_busy) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    cam_write_enable = 1'b0;
    case (state)
      ST_IDLE:  req_ready        = !cam_write_busy;
      ST_ISSUE: cam_write_enable = !cam_write_busy;
      ST_RESP:  resp_valid       = 1'b1;
      default:  ;
    endcase
  end

  // Bitmap and occupancy only move once the CAM has finished the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= CAM_OP_INSERT;
      key_q       <= '0;
      addr_q      <= '0;
      status_q    <= CAM_OK;
      valid_map   <= '0;
      occupancy_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_q  <= cam_op_t'(req_op);
            key_q <= req_key;
          end
        end
        ST_DECIDE: begin
          if (op_q == CAM_OP_INSERT) begin
            if (cam_match) begin
              status_q <= CAM_EXISTS;
              addr_q   <= cam_match_addr;
            end else if (cam_full) begin
              status_q <= CAM_FULL;
              addr_q   <= '0;
            end else begin
              addr_q   <= free_addr;
            end
          end else if (cam_match) begin
            addr_q   <= cam_match_addr;
          end else begin
            status_q <= CAM_NOT_FOUND;
            addr_q   <= '0;
          end
        end
        ST_WAIT: begin
          if (!cam_write_busy) begin
            status_q <= CAM_OK;
            if (op_q == CAM_OP_INSERT) begin
              valid_map[addr_q] <= 1'b1;
              occupancy_q       <= occupancy_q + OCC_ONE;
            end else begin
              valid_map[addr_q] <= 1'b0;
              occupancy_q       <= occupancy_q - OCC_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_status      = status_q;
  assign resp_addr        = addr_q;
  assign occupancy        = occupancy_q;
  assign cam_compare_data = key_q;
  assign cam_write_addr   = addr_q;
  assign cam_write_data   = key_q;
  assign cam_write_delete = (op_q == CAM_OP_DELETE);

endmodule

// File: tb/tb_cam_entry_manager.sv
// Directed bench for cam_entry_manager with a behavioural CAM: init sweep, registered compare,
// 4-cycle insert busy and 2-cycle delete busy.
module tb_cam_entry_manager;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [DW-1:0] req_key;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic [AW-1:0] resp_addr;
  logic [AW:0]   occupancy;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic          cam_write_delete;
  logic          cam_write_enable;
  logic          cam_write_busy;
  logic [DW-1:0] cam_compare_data;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;

  always #5 clk = ~clk;

  cam_entry_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_key          (req_key),
    .resp_valid       (resp_valid),
    .resp_status      (resp_status),
    .resp_addr        (resp_addr),
    .occupancy        (occupancy),
    .cam_write_addr   (cam_write_addr),
    .cam_write_data   (cam_write_data),
    .cam_write_delete (cam_write_delete),
    .cam_write_enable (cam_write_enable),
    .cam_write_busy   (cam_write_busy),
    .cam_compare_data (cam_compare_data),
    .cam_match        (cam_match),
    .cam_match_addr   (cam_match_addr)
  );

  // Behavioural CAM
  logic [DW-1:0] mem_key [N];
  logic [N-1:0]  mem_vld;
  int            init_cnt;
  int            wr_cnt;
  bit            we_busy_viol = 1'b0;

  assign cam_write_busy = (init_cnt != 0) || (wr_cnt != 0);

  always @(posedge clk) begin
    if (rst) begin
      mem_vld        <= '0;
      init_cnt       <= N;
      wr_cnt         <= 0;
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
    end else begin
      if (init_cnt != 0) init_cnt <= init_cnt - 1;
      if (wr_cnt != 0)   wr_cnt   <= wr_cnt - 1;
      if (cam_write_enable) begin
        if (cam_write_busy) we_busy_viol <= 1'b1;
        mem_key[cam_write_addr] <= cam_write_data;
        mem_vld[cam_write_addr] <= !cam_write_delete;
        wr_cnt <= cam_write_delete ? 2 : 4;
      end
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (mem_vld[i] && mem_key[i] == cam_compare_data) begin
          cam_match      <= 1'b1;
          cam_match_addr <= AW'(i);
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  int            r_lat, r_we_lat, r_we_cnt;
  logic [1:0]    r_st;
  logic [AW-1:0] r_addr, r_we_addr;
  logic [DW-1:0] r_we_data, r_cmp;
  logic          r_we_del;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge; latency is counted in cycles from the accepting cycle T.
  task automatic do_req(input logic op, input logic [DW-1:0] key);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    @(negedge clk);
    req_valid = 1'b0;
    r_cmp     = cam_compare_data;
    r_lat     = 1;
    r_we_cnt  = 0;
    r_we_lat  = 0;
    while (!resp_valid && r_lat < 60) begin
      if (cam_write_enable) begin
        r_we_cnt++;
        r_we_lat  = r_lat;
        r_we_addr = cam_write_addr;
        r_we_data = cam_write_data;
        r_we_del  = cam_write_delete;
      end
      @(negedge clk);
      r_lat++;
    end
    chk("resp_seen", resp_valid, 1);
    r_st   = resp_status;
    r_addr = resp_addr;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_key   = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_status", resp_status, 0);
    chk("rst_resp_addr", resp_addr, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_write_enable", cam_write_enable, 0);
    chk("rst_compare_data", cam_compare_data, 0);
    rst = 1'b0;

    @(negedge clk);
    chk("init_gate_ready", req_ready, 0);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("init_done_ready", req_ready, 1);
    chk("init_occupancy", occupancy, 0);

    // First insert takes the lowest address and the full write handshake.
    do_req(1'b0, 64'h1234);
    chk("ins_status", r_st, 0);
    chk("ins_addr", r_addr, 0);
    chk("ins_latency", r_lat, 9);
    chk("ins_we_cycle", r_we_lat, 3);
    chk("ins_we_count", r_we_cnt, 1);
    chk("ins_we_addr", r_we_addr, 0);
    chk("ins_we_data", r_we_data, 64'h1234);
    chk("ins_we_delete", r_we_del, 0);
    chk("ins_compare_data", r_cmp, 64'h1234);
    chk("ins_occupancy", occupancy, 1);
    @(negedge clk);
    chk("b2b_ready", req_ready, 1);

    do_req(1'b0, 64'h1234);
    chk("dup_status", r_st, 1);
    chk("dup_addr", r_addr, 0);
    chk("dup_latency", r_lat, 3);
    chk("dup_no_we", r_we_cnt, 0);
    chk("dup_occupancy", occupancy, 1);

    for (int i = 1; i < N; i++) begin
      do_req(1'b0, 64'h1000 + 64'(i));
      chk("fill_status", r_st, 0);
      chk("fill_addr", r_addr, 64'(i));
    end
    chk("fill_occupancy", occupancy, 32);

    do_req(1'b0, 64'h9999);
    chk("full_status", r_st, 2);
    chk("full_addr", r_addr, 0);
    chk("full_latency", r_lat, 3);
    chk("full_no_we", r_we_cnt, 0);
    chk("full_occupancy", occupancy, 32);

    do_req(1'b1, 64'h1005);
    chk("del_status", r_st, 0);
    chk("del_addr", r_addr, 5);
    chk("del_latency", r_lat, 7);
    chk("del_we_delete", r_we_del, 1);
    chk("del_we_addr", r_we_addr, 5);
    chk("del_occupancy", occupancy, 31);

    do_req(1'b0, 64'h5555);
    chk("reuse_status", r_st, 0);
    chk("reuse_addr", r_addr, 5);
    chk("reuse_occupancy", occupancy, 32);

    do_req(1'b1, 64'hDEAD);
    chk("missing_status", r_st, 3);
    chk("missing_addr", r_addr, 0);
    chk("missing_latency", r_lat, 3);
    chk("missing_occupancy", occupancy, 32);

    do_req(1'b1, 64'h1003);
    chk("del3_addr", r_addr, 3);
    chk("del3_occupancy", occupancy, 31);

    // Abandon an insert while it waits on the CAM write.
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_key   = 64'hBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_write_busy", cam_write_busy, 1);
    rst = 1'b1;
    n   = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    rst = 1'b0;
    chk("mid_rst_occupancy", occupancy, 0);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      if (resp_valid) n = 1000;
      n++;
    end
    chk("mid_rst_no_resp", (n < 1000), 1);
    chk("mid_rst_ready", req_ready, 1);

    do_req(1'b0, 64'hBEEF);
    chk("post_rst_status", r_st, 0);
    chk("post_rst_addr", r_addr, 0);
    chk("post_rst_latency", r_lat, 9);
    chk("post_rst_occupancy", occupancy, 1);

    chk("we_never_while_busy", we_busy_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
